// File: rtl/qrs_pkg.sv
// Shared types and constants for the QRS detection scheduler.
package qrs_pkg;

  typedef enum logic [1:0] {
    ST_LEARN   = 2'd0,
    ST_SEARCH  = 2'd1,
    ST_TRACK   = 2'd2,
    ST_REFRACT = 2'd3
  } qrs_state_e;

  localparam int SPK_SHIFT = 3;
  localparam int THR_SHIFT = 1;
  localparam int THR_FLOOR = 1;

endpackage

// File: rtl/qrs_rr_timer.sv
// Sample timestamp, peak-position registers and modular R-R interval.
module qrs_rr_timer #(
  parameter int              RR_W   = 32,
  parameter logic [RR_W-1:0] TS_RST = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sample_valid_i,
  input  logic            pk_load_i,
  input  logic            det_i,
  output logic            rr_valid_o,
  output logic [RR_W-1:0] r_r_int_o
);

  logic [RR_W-1:0] tstamp_q, pk_t_q, last_pk_t_q, rr_q;
  logic [RR_W-1:0] pk_t_cur;
  logic            first_q, rr_valid_q;

  // A peak can be captured and declared on the same sample (TRACK timeout).
  assign pk_t_cur = pk_load_i ? tstamp_q : pk_t_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tstamp_q    <= TS_RST;
      pk_t_q      <= '0;
      last_pk_t_q <= '0;
      rr_q        <= '0;
      first_q     <= 1'b1;
      rr_valid_q  <= 1'b0;
    end else begin
      rr_valid_q <= 1'b0;
      if (sample_valid_i) begin
        tstamp_q <= tstamp_q + RR_W'(1);
        if (pk_load_i) pk_t_q <= tstamp_q;
        if (det_i) begin
          last_pk_t_q <= pk_t_cur;
          first_q     <= 1'b0;
          if (!first_q) begin
            rr_q       <= pk_t_cur - last_pk_t_q;
            rr_valid_q <= 1'b1;
          end
        end
      end
    end
  end

  assign rr_valid_o = rr_valid_q;
  assign r_r_int_o  = rr_q;

endmodule

// File: rtl/qrs_sched.sv
// QRS detection scheduler: adaptive threshold, peak tracking, R-R output.
//   state   | meaning
//   LEARN   | collect max over initial window to seed spk/thr
//   SEARCH  | wait for sample above thr; halve thr on long silence
//   TRACK   | follow rising peak until it falls below half or times out
//   REFRACT | blank input after a detection
module qrs_sched
  import qrs_pkg::*;
#(
  parameter int              DW          = 16,
  parameter int              RR_W        = 32,
  parameter int              LEARN_LEN   = 360,
  parameter int              REFRACT_LEN = 72,
  parameter int              RR_MAX      = 720,
  parameter logic [RR_W-1:0] TS_RST      = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sample_valid,
  input  logic [DW-1:0]   slope_mag,
  output logic            r_peak,
  output logic            rr_valid,
  output logic [RR_W-1:0] r_r_int,
  output logic [DW-1:0]   thr,
  output logic [1:0]      state
);

  localparam int CNT_TOP = (RR_MAX > LEARN_LEN)
                         ? ((RR_MAX > REFRACT_LEN) ? RR_MAX : REFRACT_LEN)
                         : ((LEARN_LEN > REFRACT_LEN) ? LEARN_LEN : REFRACT_LEN);
  localparam int CW = $clog2(CNT_TOP + 1);

  qrs_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] pk_val_q, pk_val_d, spk_q, spk_d, thr_q, thr_d;
  logic          r_peak_q;
  logic [DW-1:0] pk_new, spk_new, thr_half, thr_to;
  logic [DW+2:0] spk_sum;
  logic          pk_load, det;

  assign pk_new   = (slope_mag >= pk_val_q) ? slope_mag : pk_val_q;
  assign spk_sum  = ((DW+3)'(spk_q) << SPK_SHIFT) - (DW+3)'(spk_q) + (DW+3)'(pk_new);
  assign spk_new  = DW'(spk_sum >> SPK_SHIFT);
  assign thr_half = thr_q >> THR_SHIFT;
  assign thr_to   = (thr_half < DW'(THR_FLOOR)) ? DW'(THR_FLOOR) : thr_half;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_LEARN;
      cnt_q    <= '0;
      pk_val_q <= '0;
      spk_q    <= '0;
      thr_q    <= '0;
      r_peak_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pk_val_q <= pk_val_d;
      spk_q    <= spk_d;
      thr_q    <= thr_d;
      r_peak_q <= det;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pk_val_d = pk_val_q;
    spk_d    = spk_q;
    thr_d    = thr_q;
    pk_load  = 1'b0;
    det      = 1'b0;
    if (sample_valid) begin
      case (state_q)
        ST_LEARN: begin
          pk_val_d = pk_new;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CW'(LEARN_LEN - 1)) begin
            spk_d   = pk_new;
            thr_d   = pk_new >> THR_SHIFT;
            cnt_d   = '0;
            state_d = ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          if (slope_mag > thr_q) begin
            pk_val_d = slope_mag;
            pk_load  = 1'b1;
            cnt_d    = '0;
            state_d  = ST_TRACK;
          end else if (cnt_q == CW'(RR_MAX - 1)) begin
            thr_d = thr_to;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_TRACK: begin
          pk_val_d = pk_new;
          pk_load  = (slope_mag >= pk_val_q);
          cnt_d    = cnt_q + 1'b1;
          if ((slope_mag < (pk_val_q >> 1)) || (cnt_q == CW'(REFRACT_LEN - 1))) begin
            det     = 1'b1;
            spk_d   = spk_new;
            thr_d   = spk_new >> THR_SHIFT;
            cnt_d   = '0;
            state_d = ST_REFRACT;
          end
        end
        ST_REFRACT: begin
          if (cnt_q == CW'(REFRACT_LEN - 1)) begin
            cnt_d   = '0;
            state_d = ST_SEARCH;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ST_LEARN;
      endcase
    end
  end

  qrs_rr_timer #(
    .RR_W   (RR_W),
    .TS_RST (TS_RST)
  ) u_rr_timer (
    .clk            (clk),
    .rst            (rst),
    .sample_valid_i (sample_valid),
    .pk_load_i      (pk_load),
    .det_i          (det),
    .rr_valid_o     (rr_valid),
    .r_r_int_o      (r_r_int)
  );

  assign r_peak = r_peak_q;
  assign thr    = thr_q;
  assign state  = state_q;

endmodule

// File: doc/qrs_sched.md
Name: qrs_sched

Overview:
- Detection controller/scheduler for the QRS datapath. Consumes the per-sample slope-energy stream and sequences detection through learn, search, peak-track and refractory phases.
- Maintains an adaptive threshold.
- Emits the one-cycle r_peak strobe and the 32-bit R-R interval used downstream.
- Sits between the slope/integrator stage and the R-R consumer.

Parameters:
- DW, 16, width of slope_mag sample.
- RR_W, 32, width of timestamp and r_r_int.
- LEARN_LEN, 360, valid samples in initial learning window (1 s at 360 Hz).
- REFRACT_LEN, 72, valid samples blanked after a detection (200 ms); also max TRACK length.
- RR_MAX, 720, valid samples in SEARCH without detection before threshold is halved.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- sample_valid  in  1  slope_mag valid this cycle; all counters advance only on these cycles.
- slope_mag  in  DW  unsigned slope-energy sample.
- r_peak  out  1  one-clk pulse per detected R peak.
- rr_valid  out  1  one-clk pulse, coincident with r_peak, when r_r_int is a true interval.
- r_r_int  out  RR_W  samples between last two peak positions; holds between updates.
- thr  out  DW  current detection threshold.
- state  out  2  LEARN=0, SEARCH=1, TRACK=2, REFRACT=3.

Behaviour:
- Reset (rst=0 at a clk edge):
  - r_peak=0, rr_valid=0, r_r_int=0, thr=0, state=LEARN.
  - Internal registers cleared: spk, pk_val, pk_t, last_pk_t, tstamp, phase counter, first flag set.
  - Reset wins over a simultaneous sample_valid.
- tstamp: RR_W-bit counter; +1 on every sample_valid; wraps modulo 2^RR_W.
- Cycles with sample_valid=0 change nothing except clearing r_peak/rr_valid.
- LEARN:
  - Track max of slope_mag over LEARN_LEN valid samples.
  - After the last one: spk=max, thr=max>>1, go to SEARCH.
- SEARCH:
  - If slope_mag > thr (strict): pk_val=slope_mag, pk_t=tstamp, go to TRACK.
  - Otherwise increment to_cnt. When to_cnt reaches RR_MAX: thr=max(thr>>1,1), to_cnt=0.
  - to_cnt is cleared on entry to SEARCH.
- TRACK:
  - If slope_mag >= pk_val: pk_val=slope_mag, pk_t=tstamp. Ties move the peak later.
  - Detection occurs when slope_mag < (pk_val>>1), or when TRACK has lasted REFRACT_LEN valid samples.
  - On detection:
    - r_peak=1 next clk.
    - spk=(7*spk+pk_val)>>3, computed at DW+3 bits and truncated.
    - thr=spk_new>>1.
    - If first flag is clear: r_r_int=pk_t-last_pk_t (modulo 2^RR_W) and rr_valid=1. Otherwise clear the first flag; r_r_int is unchanged and rr_valid=0.
    - last_pk_t=pk_t.
    - Go to REFRACT.
- REFRACT:
  - Ignore slope_mag for REFRACT_LEN valid samples, then go to SEARCH.
- Latency:
  - r_peak/rr_valid/r_r_int update on the clk edge that samples the detecting sample_valid.
  - Visible one cycle after that input cycle.
- Reset mid-TRACK or mid-REFRACT: no r_peak is emitted; restart in LEARN with first flag set.
- slope_mag=0 throughout LEARN:
  - thr=0, so any nonzero sample triggers TRACK.
  - Timeout halving floors thr at 1.

Decomposition:
- qrs_pkg holds:
  - state enum (LEARN/SEARCH/TRACK/REFRACT).
  - SPK_SHIFT=3.
  - THR_SHIFT=1.
  - THR_FLOOR=1.
- Sub-module qrs_rr_timer owns:
  - tstamp counter.
  - pk_t/last_pk_t registers.
  - modular interval subtraction.
  - first-peak flag.
- qrs_sched holds the FSM, phase counters, spk/thr arithmetic.

Test Plan (bench parameters: LEARN_LEN=8, REFRACT_LEN=4, RR_MAX=40, DW=16):
- Reset: hold rst=0 for 2 clks with sample_valid toggling -> r_peak=0, rr_valid=0, r_r_int=0, thr=0, state=0.
- Learn: 8 valid samples {50,120,400,90,10,300,0,60} -> thr=200, state=SEARCH after 8th sample.
- First peak: samples 100,300,500,450,240 -> TRACK at 300, peak 500, detection on 240. Required response:
  - r_peak pulse 1 clk later, rr_valid=0.
  - spk=412, thr=206.
  - 4 ignored samples in REFRACT.
- Second peak: second peak sample placed 30 valid samples after the first (sample_valid gaps inserted) -> r_r_int=30, rr_valid=1 pulse with r_peak.
- Timeout: after REFRACT, 40 samples of value 50 -> thr 206->103; a further 40 -> 51.
- Reset mid-TRACK and tstamp wrap:
  - rst=0 during TRACK -> no r_peak, state=LEARN.
  - Separately, force tstamp near 2^32-5 with peaks 10 samples apart -> r_r_int=10.
